// File: rtl/fwd_hazard_scoreboard.sv
// EX-stage forwarding selects, ID load-use/multi-cycle hazard stalls and a single-entry MUL/DIV countdown scoreboard.
// Optional FWD_PERF_CNT_EN adds saturating stall/forward cycle counters.
module fwd_hazard_scoreboard #(
   parameter int RW      = 5,
   parameter int NUM_SRC = 2,
   parameter int LAT_W   = 4
) (
   input  logic                   i_clk,
   input  logic                   i_reset,
   input  logic                   i_id_valid,
   input  logic [NUM_SRC*RW-1:0]  i_id_rs,
   input  logic [NUM_SRC-1:0]     i_id_rs_used,
   input  logic [RW-1:0]          i_id_rd,
   input  logic                   i_id_regwrite,
   input  logic                   i_id_mc_start,
   input  logic [LAT_W-1:0]       i_id_mc_lat,
   input  logic [NUM_SRC*RW-1:0]  i_ex_rs,
   input  logic [RW-1:0]          i_ex_rd,
   input  logic                   i_ex_regwrite,
   input  logic                   i_ex_memread,
   input  logic [RW-1:0]          i_mem_rd,
   input  logic                   i_mem_regwrite,
   input  logic [RW-1:0]          i_wb_rd,
   input  logic                   i_wb_regwrite,
   output logic [2*NUM_SRC-1:0]   o_ex_fwd_sel,
   output logic                   o_stall_id,
   output logic                   o_flush_ex,
   output logic                   o_mc_busy,
   output logic [RW-1:0]          o_mc_rd,
   output logic                   o_mc_done
`ifdef FWD_PERF_CNT_EN
   ,
   output logic [31:0]            o_perf_stall_cnt,
   output logic [31:0]            o_perf_fwd_cnt
`endif
);

   localparam logic [0:0]       S_IDLE = 1'b0;
   localparam logic [0:0]       S_BUSY = 1'b1;
   localparam logic [RW-1:0]    C_X0   = '0;
   localparam logic [LAT_W-1:0] C_ZERO = '0;
   localparam logic [LAT_W-1:0] C_ONE  = LAT_W'(1);

   logic [0:0]          r_state;
   logic [RW-1:0]       r_mc_rd;
   logic [LAT_W-1:0]    r_cnt;
   logic                r_mc_done;
   logic [0:0]          w_state_nxt;
   logic [RW-1:0]       w_mc_rd_nxt;
   logic [LAT_W-1:0]    w_cnt_nxt;
   logic [2*NUM_SRC-1:0] w_fwd_sel;
   logic                w_busy;
   logic                w_ld_use;
   logic                w_raw;
   logic                w_waw;
   logic                w_struct;
   logic                w_stall;

   assign w_busy = (r_state == S_BUSY);

   // Per-source forward select: youngest producer (MEM) wins over WB, x0 never forwarded.
   always_comb begin
      w_fwd_sel = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (i_mem_regwrite && (i_mem_rd != C_X0) && (i_mem_rd == i_ex_rs[i*RW +: RW])) begin
            w_fwd_sel[2*i +: 2] = 2'b01;
         end else if (i_wb_regwrite && (i_wb_rd != C_X0) && (i_wb_rd == i_ex_rs[i*RW +: RW])) begin
            w_fwd_sel[2*i +: 2] = 2'b10;
         end else begin
            w_fwd_sel[2*i +: 2] = 2'b00;
         end
      end
   end

   // ID hazard detection against the EX load and the outstanding multi-cycle op.
   always_comb begin
      w_ld_use = 1'b0;
      w_raw    = 1'b0;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (i_id_rs_used[i] && i_ex_memread && i_ex_regwrite && (i_ex_rd != C_X0) &&
             (i_id_rs[i*RW +: RW] == i_ex_rd)) begin
            w_ld_use = 1'b1;
         end else begin
            w_ld_use = w_ld_use;
         end
         if (i_id_rs_used[i] && w_busy && (r_mc_rd != C_X0) && (i_id_rs[i*RW +: RW] == r_mc_rd)) begin
            w_raw = 1'b1;
         end else begin
            w_raw = w_raw;
         end
      end
      w_waw    = w_busy && i_id_regwrite && (i_id_rd != C_X0) && (i_id_rd == r_mc_rd);
      w_struct = w_busy && i_id_mc_start;
      w_stall  = i_id_valid && (w_ld_use || w_raw || w_waw || w_struct);
   end

   // Scoreboard next state; the done cycle still counts as busy so a new issue waits one cycle.
   always_comb begin
      w_state_nxt = r_state;
      w_mc_rd_nxt = r_mc_rd;
      w_cnt_nxt   = r_cnt;
      case (r_state)
         S_IDLE: begin
            if (i_id_valid && i_id_mc_start && !w_stall) begin
               w_state_nxt = S_BUSY;
               w_mc_rd_nxt = i_id_rd;
               w_cnt_nxt   = (i_id_mc_lat == C_ZERO) ? C_ONE : i_id_mc_lat;
            end else begin
               w_state_nxt = S_IDLE;
            end
         end
         S_BUSY: begin
            if (r_cnt <= C_ONE) begin
               w_state_nxt = S_IDLE;
               w_cnt_nxt   = C_ZERO;
            end else begin
               w_cnt_nxt   = r_cnt - C_ONE;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = C_ZERO;
         end
      endcase
   end

   // Scoreboard registers; mc_done is decoded one cycle early so it is a clean flop output.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state   <= S_IDLE;
         r_mc_rd   <= '0;
         r_cnt     <= '0;
         r_mc_done <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_mc_rd   <= w_mc_rd_nxt;
         r_cnt     <= w_cnt_nxt;
         r_mc_done <= (w_state_nxt == S_BUSY) && (w_cnt_nxt == C_ONE);
      end
   end

`ifdef FWD_PERF_CNT_EN
   logic [31:0] r_perf_stall_cnt;
   logic [31:0] r_perf_fwd_cnt;

   // Saturating event counters.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_perf_stall_cnt <= 32'd0;
         r_perf_fwd_cnt   <= 32'd0;
      end else begin
         if (w_stall && (r_perf_stall_cnt != 32'hFFFF_FFFF)) begin
            r_perf_stall_cnt <= r_perf_stall_cnt + 32'd1;
         end
         if ((w_fwd_sel != '0) && (r_perf_fwd_cnt != 32'hFFFF_FFFF)) begin
            r_perf_fwd_cnt <= r_perf_fwd_cnt + 32'd1;
         end
      end
   end

   assign o_perf_stall_cnt = r_perf_stall_cnt;
   assign o_perf_fwd_cnt   = r_perf_fwd_cnt;
`endif

   assign o_ex_fwd_sel = w_fwd_sel;
   assign o_stall_id   = w_stall;
   assign o_flush_ex   = w_stall;
   assign o_mc_busy    = w_busy;
   assign o_mc_rd      = r_mc_rd;
   assign o_mc_done    = r_mc_done;

endmodule
